// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard controller and multiply/divide scheduler for a 5-stage MIPS pipeline.
// It decides each cycle whether fetch advances, stalls or flushes, inserts
// ID/EX bubbles, and sequences the shared multi-cycle MD unit.
//
// Ports:
//   Clk, Rst                  pipeline clock (state on negedge), async active-high reset
//   ID_Rs, ID_Rt              ID source register numbers
//   ID_UsesRs, ID_UsesRt      ID instruction reads Rs / Rt
//   ID_MdUse                  ID instruction starts an MD op or reads HI/LO
//   EX_Rw                     EX destination register (after RegDst mux)
//   EX_RegWr, EX_MemtoReg     EX control bits
//   EX_BrTaken, EX_Jump       control transfer resolved in EX
//   EX_MdStart                EX instruction launches an MD op
//   PC_WrEn, IF_ID_WrEn       fetch-side load enables
//   IF_ID_Flush               IF/ID loads a NOP
//   ID_EX_Clrn                active-low clear of ID/EX (0 = bubble)
//   Md_Busy, Md_ResultVld     MD unit status
//   Perf_StallCnt/FlushCnt/MdCnt  performance counters
//
// Parameter MD_LATENCY (2..255): MD latency from start edge to end of the
// result-valid cycle.
// Macro PIPE_CTRL_PERF_EN: builds the performance counters; otherwise the
// Perf_* ports are tied to zero.
//
// state   | meaning
// MD_IDLE | no MD op in flight
// MD_BUSY | MD unit computing, cnt counts down to 1
// MD_DONE | result valid, HI/LO written this cycle

module pipe_hazard_ctrl #(
   parameter int MD_LATENCY = 8
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [4:0]  ID_Rs,
   input  logic [4:0]  ID_Rt,
   input  logic        ID_UsesRs,
   input  logic        ID_UsesRt,
   input  logic        ID_MdUse,
   input  logic [4:0]  EX_Rw,
   input  logic        EX_RegWr,
   input  logic        EX_MemtoReg,
   input  logic        EX_BrTaken,
   input  logic        EX_Jump,
   input  logic        EX_MdStart,
   output logic        PC_WrEn,
   output logic        IF_ID_WrEn,
   output logic        IF_ID_Flush,
   output logic        ID_EX_Clrn,
   output logic        Md_Busy,
   output logic        Md_ResultVld,
   output logic [31:0] Perf_StallCnt,
   output logic [31:0] Perf_FlushCnt,
   output logic [31:0] Perf_MdCnt
);

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   localparam logic [7:0] CNT_LOAD = 8'(MD_LATENCY - 1);

   md_state_e  state_q, state_d;
   logic [7:0] cnt_q, cnt_d;

   logic load_use, md_haz, redirect;

   assign load_use = EX_MemtoReg & EX_RegWr & (EX_Rw != 5'd0) &
                     ((ID_UsesRs & (ID_Rs == EX_Rw)) | (ID_UsesRt & (ID_Rt == EX_Rw)));
   assign md_haz   = ID_MdUse & (Md_Busy | EX_MdStart);
   assign redirect = EX_BrTaken | EX_Jump;

   always_ff @(negedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= MD_IDLE;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      Md_Busy      = 1'b0;
      Md_ResultVld = 1'b0;
      case (state_q)
         MD_IDLE: begin
            if (EX_MdStart) begin
               state_d = MD_BUSY;
               cnt_d   = CNT_LOAD;
            end
         end
         MD_BUSY: begin
            Md_Busy = 1'b1;
            // <= 1 rather than == 1 so a corrupted zero count cannot wrap to 255
            if (cnt_q <= 8'd1) begin
               state_d = MD_DONE;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         MD_DONE: begin
            Md_ResultVld = 1'b1;
            if (EX_MdStart) begin
               state_d = MD_BUSY;
               cnt_d   = CNT_LOAD;
            end else begin
               state_d = MD_IDLE;
            end
         end
         default: begin
            state_d = MD_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   always_comb begin
      PC_WrEn     = 1'b1;
      IF_ID_WrEn  = 1'b1;
      IF_ID_Flush = 1'b0;
      ID_EX_Clrn  = 1'b1;
      if (Rst) begin
         PC_WrEn     = 1'b0;
         IF_ID_WrEn  = 1'b0;
         IF_ID_Flush = 1'b1;
         ID_EX_Clrn  = 1'b0;
      end else if (redirect) begin
         IF_ID_Flush = 1'b1;
         ID_EX_Clrn  = 1'b0;
      end else if (load_use | md_haz) begin
         PC_WrEn    = 1'b0;
         IF_ID_WrEn = 1'b0;
         ID_EX_Clrn = 1'b0;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt_q, flush_cnt_q, md_cnt_q;
   logic        stall_sel, md_done_entry;

   assign stall_sel     = ~redirect & (load_use | md_haz);
   assign md_done_entry = (state_q == MD_BUSY) && (state_d == MD_DONE);

   always_ff @(negedge Clk or posedge Rst) begin
      if (Rst) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
         md_cnt_q    <= 32'd0;
      end else begin
         if (stall_sel)     stall_cnt_q <= stall_cnt_q + 32'd1;
         if (redirect)      flush_cnt_q <= flush_cnt_q + 32'd1;
         if (md_done_entry) md_cnt_q    <= md_cnt_q + 32'd1;
      end
   end

   assign Perf_StallCnt = stall_cnt_q;
   assign Perf_FlushCnt = flush_cnt_q;
   assign Perf_MdCnt    = md_cnt_q;
`else
   assign Perf_StallCnt = 32'd0;
   assign Perf_FlushCnt = 32'd0;
   assign Perf_MdCnt    = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

`ifdef PIPE_CTRL_PERF_EN
   localparam bit PERF_EN = 1'b1;
`else
   localparam bit PERF_EN = 1'b0;
`endif

   logic        Clk, Rst;
   logic [4:0]  ID_Rs, ID_Rt, EX_Rw;
   logic        ID_UsesRs, ID_UsesRt, ID_MdUse;
   logic        EX_RegWr, EX_MemtoReg, EX_BrTaken, EX_Jump, EX_MdStart;
   logic        PC_WrEn, IF_ID_WrEn, IF_ID_Flush, ID_EX_Clrn, Md_Busy, Md_ResultVld;
   logic [31:0] Perf_StallCnt, Perf_FlushCnt, Perf_MdCnt;
   logic        pc2, ifw2, iff2, clrn2, busy2, vld2;
   logic [31:0] ps2, pf2, pm2;

   int checks = 0;
   int errors = 0;
   int exp_stall = 0, exp_flush = 0, exp_md = 0;

   pipe_hazard_ctrl #(.MD_LATENCY(8)) u_dut (
      .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
      .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_MdUse(ID_MdUse),
      .EX_Rw(EX_Rw), .EX_RegWr(EX_RegWr), .EX_MemtoReg(EX_MemtoReg),
      .EX_BrTaken(EX_BrTaken), .EX_Jump(EX_Jump), .EX_MdStart(EX_MdStart),
      .PC_WrEn(PC_WrEn), .IF_ID_WrEn(IF_ID_WrEn), .IF_ID_Flush(IF_ID_Flush),
      .ID_EX_Clrn(ID_EX_Clrn), .Md_Busy(Md_Busy), .Md_ResultVld(Md_ResultVld),
      .Perf_StallCnt(Perf_StallCnt), .Perf_FlushCnt(Perf_FlushCnt), .Perf_MdCnt(Perf_MdCnt)
   );

   // minimum-latency instance sharing the same stimulus
   pipe_hazard_ctrl #(.MD_LATENCY(2)) u_dut2 (
      .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
      .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_MdUse(ID_MdUse),
      .EX_Rw(EX_Rw), .EX_RegWr(EX_RegWr), .EX_MemtoReg(EX_MemtoReg),
      .EX_BrTaken(EX_BrTaken), .EX_Jump(EX_Jump), .EX_MdStart(EX_MdStart),
      .PC_WrEn(pc2), .IF_ID_WrEn(ifw2), .IF_ID_Flush(iff2),
      .ID_EX_Clrn(clrn2), .Md_Busy(busy2), .Md_ResultVld(vld2),
      .Perf_StallCnt(ps2), .Perf_FlushCnt(pf2), .Perf_MdCnt(pm2)
   );

   initial Clk = 1'b1;
   always #5 Clk = ~Clk;

   // inputs change 1 time unit after the active (negative) edge
   task automatic next_cycle();
      @(negedge Clk);
      #1;
   endtask

   task automatic idle_inputs();
      ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0; ID_MdUse = 1'b0;
      EX_Rw = 5'd0; EX_RegWr = 1'b0; EX_MemtoReg = 1'b0;
      EX_BrTaken = 1'b0; EX_Jump = 1'b0; EX_MdStart = 1'b0;
   endtask

   task automatic check_perf(input string tag);
      logic [31:0] es, ef, em;
      es = PERF_EN ? 32'(exp_stall) : 32'd0;
      ef = PERF_EN ? 32'(exp_flush) : 32'd0;
      em = PERF_EN ? 32'(exp_md)    : 32'd0;
      checks++;
      if (Perf_StallCnt !== es) begin
         errors++; $display("FAIL %s stall_cnt: got %0d expected %0d", tag, Perf_StallCnt, es);
      end
      checks++;
      if (Perf_FlushCnt !== ef) begin
         errors++; $display("FAIL %s flush_cnt: got %0d expected %0d", tag, Perf_FlushCnt, ef);
      end
      checks++;
      if (Perf_MdCnt !== em) begin
         errors++; $display("FAIL %s md_cnt: got %0d expected %0d", tag, Perf_MdCnt, em);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      Rst = 1'b1;
      next_cycle(); next_cycle();
      Rst = 1'b0;
      next_cycle();
      #2 Rst = 1'b1;   // asserted mid-cycle
      #1;
      checks++;
      if ({PC_WrEn, IF_ID_WrEn, IF_ID_Flush, ID_EX_Clrn} !== 4'b0010) begin
         errors++; $display("FAIL reset_outputs: got %b expected 0010",
                            {PC_WrEn, IF_ID_WrEn, IF_ID_Flush, ID_EX_Clrn});
      end
      next_cycle();
      Rst = 1'b0;
      #2;
      checks++;
      if ({Md_Busy, Md_ResultVld} !== 2'b00) begin
         errors++; $display("FAIL reset_md: got %b expected 00", {Md_Busy, Md_ResultVld});
      end
      checks++;
      if ({PC_WrEn, IF_ID_WrEn, IF_ID_Flush, ID_EX_Clrn} !== 4'b1101) begin
         errors++; $display("FAIL post_reset_flow: got %b expected 1101",
                            {PC_WrEn, IF_ID_WrEn, IF_ID_Flush, ID_EX_Clrn});
      end
      exp_stall = 0; exp_flush = 0; exp_md = 0;
      check_perf("reset");
   endtask

   task automatic test_load_use();
      // lw $5 in EX, ID reads $5 through Rt
      EX_MemtoReg = 1'b1; EX_RegWr = 1'b1; EX_Rw = 5'd5;
      ID_Rt = 5'd5; ID_UsesRt = 1'b1; ID_Rs = 5'd3; ID_UsesRs = 1'b1;
      #2;
      checks++;
      if ({PC_WrEn, IF_ID_WrEn, IF_ID_Flush, ID_EX_Clrn} !== 4'b0000) begin
         errors++; $display("FAIL load_use_stall: got %b expected 0000",
                            {PC_WrEn, IF_ID_WrEn, IF_ID_Flush, ID_EX_Clrn});
      end
      next_cycle(); exp_stall++;
      // bubble now in EX
      EX_MemtoReg = 1'b0; EX_RegWr = 1'b0; EX_Rw = 5'd0;
      #2;
      checks++;
      if ({PC_WrEn, IF_ID_WrEn, IF_ID_Flush, ID_EX_Clrn} !== 4'b1101) begin
         errors++; $display("FAIL load_use_resume: got %b expected 1101",
                            {PC_WrEn, IF_ID_WrEn, IF_ID_Flush, ID_EX_Clrn});
      end
      next_cycle();
      // load to $0 never stalls
      EX_MemtoReg = 1'b1; EX_RegWr = 1'b1; EX_Rw = 5'd0; ID_Rt = 5'd0;
      #2;
      checks++;
      if ({PC_WrEn, ID_EX_Clrn} !== 2'b11) begin
         errors++; $display("FAIL load_use_r0: got %b expected 11", {PC_WrEn, ID_EX_Clrn});
      end
      next_cycle();
      // Rs matches but is not read
      EX_Rw = 5'd9; ID_Rs = 5'd9; ID_UsesRs = 1'b0; ID_Rt = 5'd4;
      #2;
      checks++;
      if ({PC_WrEn, ID_EX_Clrn} !== 2'b11) begin
         errors++; $display("FAIL load_use_unused_rs: got %b expected 11", {PC_WrEn, ID_EX_Clrn});
      end
      next_cycle();
      // Rs matches and is read
      ID_UsesRs = 1'b1;
      #2;
      checks++;
      if ({PC_WrEn, ID_EX_Clrn} !== 2'b00) begin
         errors++; $display("FAIL load_use_rs: got %b expected 00", {PC_WrEn, ID_EX_Clrn});
      end
      next_cycle(); exp_stall++;
      idle_inputs();
      #2;
      check_perf("load_use");
   endtask

   task automatic test_redirect();
      EX_MemtoReg = 1'b1; EX_RegWr = 1'b1; EX_Rw = 5'd7; ID_Rs = 5'd7; ID_UsesRs = 1'b1;
      EX_BrTaken = 1'b1;
      #2;
      checks++;
      if ({PC_WrEn, IF_ID_WrEn, IF_ID_Flush, ID_EX_Clrn} !== 4'b1110) begin
         errors++; $display("FAIL redirect_over_stall: got %b expected 1110",
                            {PC_WrEn, IF_ID_WrEn, IF_ID_Flush, ID_EX_Clrn});
      end
      next_cycle(); exp_flush++;
      idle_inputs();
      EX_Jump = 1'b1;
      #2;
      checks++;
      if ({PC_WrEn, IF_ID_WrEn, IF_ID_Flush, ID_EX_Clrn} !== 4'b1110) begin
         errors++; $display("FAIL jump_flush: got %b expected 1110",
                            {PC_WrEn, IF_ID_WrEn, IF_ID_Flush, ID_EX_Clrn});
      end
      next_cycle(); exp_flush++;
      idle_inputs();
      #2;
      check_perf("redirect");
   endtask

   task automatic test_md();
      int stalled = 0;
      ID_MdUse = 1'b1;
      EX_MdStart = 1'b1;
      for (int c = 0; c <= 8; c++) begin
         #2;
         if (!PC_WrEn) stalled++;
         checks++;
         if (Md_Busy !== (c >= 1 && c <= 7)) begin
            errors++; $display("FAIL md_busy c%0d: got %b expected %b", c, Md_Busy, (c >= 1 && c <= 7));
         end
         checks++;
         if (Md_ResultVld !== (c == 8)) begin
            errors++; $display("FAIL md_vld c%0d: got %b expected %b", c, Md_ResultVld, (c == 8));
         end
         checks++;
         if (vld2 !== (c == 2) || busy2 !== (c == 1)) begin
            errors++; $display("FAIL md_lat2 c%0d: got busy=%b vld=%b expected busy=%b vld=%b",
                               c, busy2, vld2, (c == 1), (c == 2));
         end
         if (c <= 7) exp_stall++;
         next_cycle();
         EX_MdStart = 1'b0;
      end
      checks++;
      if (stalled !== 8) begin
         errors++; $display("FAIL md_stall_len: got %0d expected 8", stalled);
      end
      exp_md++;
      ID_MdUse = 1'b0;
      #2;
      checks++;
      if ({Md_Busy, Md_ResultVld} !== 2'b00) begin
         errors++; $display("FAIL md_idle: got %b expected 00", {Md_Busy, Md_ResultVld});
      end
      check_perf("md");
   endtask

   task automatic test_back_to_back();
      int first = -1, second = -1, pulses = 0;
      logic busy_after_first = 1'b0;
      EX_MdStart = 1'b1;
      for (int c = 0; c < 24; c++) begin
         #2;
         if (Md_ResultVld) begin
            pulses++;
            if (first < 0) begin
               first = c;
               EX_MdStart = 1'b1;   // second op reaches EX during MD_DONE
            end else if (second < 0) begin
               second = c;
            end
         end
         if (first >= 0 && c == first + 1) busy_after_first = Md_Busy;
         next_cycle();
         EX_MdStart = 1'b0;
      end
      exp_md += 2;
      checks++;
      if (first !== 8) begin
         errors++; $display("FAIL b2b_first: got %0d expected 8", first);
      end
      checks++;
      if (second !== 16) begin
         errors++; $display("FAIL b2b_second: got %0d expected 16", second);
      end
      checks++;
      if (pulses !== 2 || busy_after_first !== 1'b1) begin
         errors++; $display("FAIL b2b_pulses: got %0d busy=%b expected 2 busy=1", pulses, busy_after_first);
      end
      check_perf("b2b");
   endtask

   task automatic test_rst_mid_md();
      int pulses = 0;
      EX_MdStart = 1'b1;
      next_cycle();
      EX_MdStart = 1'b0;
      for (int c = 1; c < 5; c++) next_cycle();   // now cnt = 3
      #2;
      checks++;
      if (Md_Busy !== 1'b1) begin
         errors++; $display("FAIL rst_md_pre: got busy=%b expected 1", Md_Busy);
      end
      Rst = 1'b1;
      #1;
      checks++;
      if ({Md_Busy, Md_ResultVld} !== 2'b00) begin
         errors++; $display("FAIL rst_md_abort: got %b expected 00", {Md_Busy, Md_ResultVld});
      end
      next_cycle();
      Rst = 1'b0;
      exp_stall = 0; exp_flush = 0; exp_md = 0;
      for (int c = 0; c < 10; c++) begin
         #2;
         if (Md_ResultVld || Md_Busy) pulses++;
         next_cycle();
      end
      checks++;
      if (pulses !== 0) begin
         errors++; $display("FAIL rst_md_no_pulse: got %0d active cycles expected 0", pulses);
      end
      check_perf("rst_md");
   endtask

   initial begin
      idle_inputs();
      Rst = 1'b1;
      test_reset();
      test_load_use();
      test_redirect();
      test_md();
      test_back_to_back();
      test_rst_mid_md();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
